// File: rtl/crono_pkg.sv
// Shared types, BCD limits and BCD helpers for the multi-channel countdown timer.
// Optional feature macro: CRONO_AUTORELOAD_EN (see crono_channel).
package crono_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_RING = 2'd2
    } ch_state_t;

    typedef enum logic [1:0] {
        CUR_NONE = 2'd0,
        CUR_SEC  = 2'd1,
        CUR_MIN  = 2'd2,
        CUR_HOUR = 2'd3
    } cursor_t;

    localparam logic [7:0] BCD_SEC_MAX  = 8'h59;
    localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
    localparam logic [7:0] BCD_HOUR_MAX = 8'h23;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_time_t;

    // Packed-BCD increment wrapping max -> 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max) begin
            r = 8'h00;
        end else if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'd1, 4'h0};
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // Packed-BCD decrement wrapping 00 -> max.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = max;
        end else if (v[3:0] == 4'h0) begin
            r = {v[7:4] - 4'd1, 4'h9};
        end else begin
            r = v - 8'd1;
        end
        return r;
    endfunction

    // One-second decrement with borrow ss -> mm -> hh; caller guarantees a nonzero time.
    function automatic bcd_time_t time_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.ss != 8'h00) begin
            r.ss = bcd_dec(t.ss, BCD_SEC_MAX);
        end else begin
            r.ss = BCD_SEC_MAX;
            if (t.mm != 8'h00) begin
                r.mm = bcd_dec(t.mm, BCD_MIN_MAX);
            end else begin
                r.mm = BCD_MIN_MAX;
                r.hh = bcd_dec(t.hh, BCD_HOUR_MAX);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crono_channel.sv
// One countdown channel: STOP/RUN/RING state, BCD time, ring tick counter.
// With CRONO_AUTORELOAD_EN the channel latches its programmed value on PROG exit
// and reloads it on expiry, staying in RUN with ring pulsed for RING_TICKS ticks.
module crono_channel
    import crono_pkg::*;
#(
    parameter int unsigned RING_TICKS = 10
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      tick,
    input  logic      prog,
    input  logic      start,
    input  logic      inc,
    input  logic      dec,
    input  cursor_t   field,
    output bcd_time_t count,
    output logic      run,
    output logic      ring
);

    localparam int unsigned RCW = (RING_TICKS > 1) ? $clog2(RING_TICKS + 1) : 1;

    ch_state_t        state_q, state_d;
    bcd_time_t        count_q, count_d;
    logic [RCW-1:0]   ring_cnt_q, ring_cnt_d;

`ifdef CRONO_AUTORELOAD_EN
    logic             ring_q, ring_d;
    logic             prog_q;
    bcd_time_t        reload_q, reload_d;

    // Auto-reload registers: ring pulse flag, PROG history and latched reload value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ring_q   <= 1'b0;
            prog_q   <= 1'b0;
            reload_q <= '0;
        end else begin
            ring_q   <= ring_d;
            prog_q   <= prog;
            reload_q <= reload_d;
        end
    end
`endif

    // Channel state, time and ring counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_STOP;
            count_q    <= '0;
            ring_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    // Next state: programming beats start/stop, which beats the tick decrement.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ring_cnt_d = ring_cnt_q;
`ifdef CRONO_AUTORELOAD_EN
        ring_d     = ring_q;
        reload_d   = reload_q;
        if (prog_q && !prog) begin
            reload_d = count_q;
        end
`endif
        if (prog) begin
            state_d    = ST_STOP;
            ring_cnt_d = '0;
`ifdef CRONO_AUTORELOAD_EN
            ring_d     = 1'b0;
`endif
            if (inc) begin
                case (field)
                    CUR_SEC:  count_d.ss = bcd_inc(count_q.ss, BCD_SEC_MAX);
                    CUR_MIN:  count_d.mm = bcd_inc(count_q.mm, BCD_MIN_MAX);
                    CUR_HOUR: count_d.hh = bcd_inc(count_q.hh, BCD_HOUR_MAX);
                    default:  ;
                endcase
            end else if (dec) begin
                case (field)
                    CUR_SEC:  count_d.ss = bcd_dec(count_q.ss, BCD_SEC_MAX);
                    CUR_MIN:  count_d.mm = bcd_dec(count_q.mm, BCD_MIN_MAX);
                    CUR_HOUR: count_d.hh = bcd_dec(count_q.hh, BCD_HOUR_MAX);
                    default:  ;
                endcase
            end
        end else if (start) begin
            ring_cnt_d = '0;
`ifdef CRONO_AUTORELOAD_EN
            ring_d     = 1'b0;
`endif
            case (state_q)
                ST_STOP: begin
                    if (count_q != '0) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end else if (tick) begin
            case (state_q)
                ST_RUN: begin
                    count_d = time_dec(count_q);
`ifdef CRONO_AUTORELOAD_EN
                    if (ring_q) begin
                        if (ring_cnt_q == RCW'(RING_TICKS - 1)) begin
                            ring_d     = 1'b0;
                            ring_cnt_d = '0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + RCW'(1);
                        end
                    end
                    if (count_d == '0) begin
                        ring_cnt_d = '0;
                        if (reload_q != '0) begin
                            count_d = reload_q;
                            ring_d  = 1'b1;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end
`else
                    if (count_d == '0) begin
                        state_d    = ST_RING;
                        ring_cnt_d = '0;
                    end
`endif
                end
                ST_RING: begin
                    if (ring_cnt_q == RCW'(RING_TICKS - 1)) begin
                        state_d    = ST_STOP;
                        ring_cnt_d = '0;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = count_q;
    assign run   = (state_q == ST_RUN);
`ifdef CRONO_AUTORELOAD_EN
    assign ring  = ring_q;
`else
    assign ring  = (state_q == ST_RING);
`endif

endmodule

// File: rtl/crono_multi.sv
// Multi-channel countdown timer: button edge detection, cursor FSM, N_CH channels
// and the display mux. Optional feature macro: CRONO_AUTORELOAD_EN.
module crono_multi
    import crono_pkg::*;
#(
    parameter  int unsigned N_CH       = 2,
    parameter  int unsigned RING_TICKS = 10,
    localparam int unsigned CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            tick,
    input  logic [CW-1:0]   ch_sel,
    input  logic            ProgramarCrono,
    input  logic            PushInicioCrono,
    input  logic            arriba,
    input  logic            abajo,
    input  logic            izquierda,
    input  logic            derecha,
    output logic [7:0]      horasSal,
    output logic [7:0]      minutosSal,
    output logic [7:0]      segundosSal,
    output logic [1:0]      Cursor,
    output logic [N_CH-1:0] CronoActivo,
    output logic [N_CH-1:0] Ring
);

    localparam int unsigned NB        = 5;
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_PUSH  = 4;

    logic [NB-1:0] btn_c;
    logic [NB-1:0] btn_q1, btn_q2;
    logic [NB-1:0] edge_c;
    logic          prog_q;
    cursor_t       cursor_q, cursor_d;
    logic          up_ev_c, dn_ev_c;
    bcd_time_t     counts [N_CH];
    bcd_time_t     sel_time_c;

    assign btn_c  = {PushInicioCrono, derecha, izquierda, abajo, arriba};
    assign edge_c = btn_q1 & ~btn_q2;

    // Two-flop button history; a rising edge is a single-cycle event.
    always_ff @(posedge clk) begin
        if (Reset) begin
            btn_q1 <= '0;
            btn_q2 <= '0;
            prog_q <= 1'b0;
        end else begin
            btn_q1 <= btn_c;
            btn_q2 <= btn_q1;
            prog_q <= ProgramarCrono;
        end
    end

    // Cursor state register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cursor_q <= CUR_NONE;
        end else begin
            cursor_q <= cursor_d;
        end
    end

    // Cursor next state: seconds on PROG entry, saturating moves, left wins a tie.
    always_comb begin
        cursor_d = cursor_q;
        if (!ProgramarCrono) begin
            cursor_d = CUR_NONE;
        end else if (!prog_q) begin
            cursor_d = CUR_SEC;
        end else if (edge_c[BTN_LEFT]) begin
            case (cursor_q)
                CUR_SEC: cursor_d = CUR_MIN;
                default: cursor_d = CUR_HOUR;
            endcase
        end else if (edge_c[BTN_RIGHT]) begin
            case (cursor_q)
                CUR_HOUR: cursor_d = CUR_MIN;
                default:  cursor_d = CUR_SEC;
            endcase
        end
    end

    // Up and down together cancel.
    assign up_ev_c = edge_c[BTN_UP] & ~edge_c[BTN_DOWN];
    assign dn_ev_c = edge_c[BTN_DOWN] & ~edge_c[BTN_UP];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic sel_c;
        assign sel_c = (ch_sel == CW'(i));

        crono_channel #(
            .RING_TICKS (RING_TICKS)
        ) u_ch (
            .clk   (clk),
            .reset (Reset),
            .tick  (tick),
            .prog  (ProgramarCrono & sel_c),
            .start (edge_c[BTN_PUSH] & ~ProgramarCrono & sel_c),
            .inc   (up_ev_c & sel_c),
            .dec   (dn_ev_c & sel_c),
            .field (cursor_q),
            .count (counts[i]),
            .run   (CronoActivo[i]),
            .ring  (Ring[i])
        );
    end

    // Display mux follows ch_sel combinationally; out-of-range selects show zero.
    always_comb begin
        sel_time_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == CW'(i)) begin
                sel_time_c = counts[i];
            end
        end
    end

    assign horasSal    = sel_time_c.hh;
    assign minutosSal  = sel_time_c.mm;
    assign segundosSal = sel_time_c.ss;
    assign Cursor      = cursor_q;

endmodule

// File: doc/crono_multi.md
CRONO_MULTI -- requirements
Module: crono_multi

Interface
REQ-001 SHALL have parameter N_CH, default 2, meaning the number of independent countdown channels (1..8).
REQ-002 SHALL have parameter RING_TICKS, default 10, meaning the number of tick strobes that ring stays asserted after expiry.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock.
REQ-004 SHALL have port Reset, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port tick, input, 1 bit, a one-cycle 1 Hz strobe.
REQ-006 SHALL have port ch_sel, input, CW=max(1,$clog2(N_CH)) bits, selecting the channel to program or display.
REQ-007 SHALL have port ProgramarCrono, input, 1 bit, a level that enables programming mode.
REQ-008 SHALL have port PushInicioCrono, input, 1 bit, the start/stop button level.
REQ-009 SHALL have ports arriba, abajo, izquierda and derecha, input, 1 bit each, as button levels.
REQ-010 SHALL have ports horasSal, minutosSal and segundosSal, output, 8 bits each, giving the selected channel's remaining time in packed BCD.
REQ-011 SHALL have port Cursor, output, 2 bits, with 0 = none, 1 = seconds, 2 = minutes, 3 = hours.
REQ-012 SHALL have port CronoActivo, output, N_CH bits, where bit i is high while channel i is RUN.
REQ-013 SHALL have port Ring, output, N_CH bits, where bit i is high while channel i is in RING.

Function
REQ-014 SHALL treat every button as a single rising-edge event, registered through two flops; a held level SHALL produce exactly one event.
REQ-015 SHALL implement per-channel states STOP, RUN and RING, plus a global PROG flag.
REQ-016 SHALL, while ProgramarCrono=1, force the selected channel to STOP with Ring cleared; other channels SHALL keep running.
REQ-017 SHALL, in PROG, move the cursor on izquierda through 1 -> 2 -> 3 -> 3 (saturating) and on derecha through 3 -> 2 -> 1 -> 1 (saturating).
REQ-018 SHALL set the cursor to 1 on entry to PROG and to 0 outside PROG.
REQ-019 SHALL, in PROG, increment the field under the cursor on arriba and decrement it on abajo, in BCD.
REQ-020 SHALL wrap seconds and minutes 59 <-> 00 and hours 23 <-> 00, with no carry into neighbouring fields.
REQ-021 SHALL ignore arriba and abajo together in the same cycle, and SHALL give izquierda and derecha together priority to izquierda.
REQ-022 SHALL, on a PushInicioCrono edge with ProgramarCrono=0, toggle the selected channel STOP <-> RUN; from RING it SHALL go to STOP with Ring cleared.
REQ-023 SHALL ignore a start request on a channel holding 00:00:00, which SHALL stay in STOP.
REQ-024 SHALL, on each tick, decrement every RUN channel by 1 s with BCD borrow (ss -> mm -> hh).
REQ-025 SHALL, when a tick takes a channel to 00:00:00, enter RING in the same cycle the count updates.
REQ-026 SHALL, in RING, count ticks and return the channel to STOP after RING_TICKS ticks, with Ring dropping that cycle.
REQ-027 SHALL apply a tick and a button edge in the same cycle on the same channel with the button winning, the decrement being discarded.
REQ-028 SHALL update outputs one cycle after the causing event; a ch_sel change SHALL be reflected combinationally on horasSal, minutosSal and segundosSal.

Reset
REQ-029 SHALL, with Reset=1 at a clk edge, set all channels to STOP with 00:00:00, CronoActivo=0, Ring=0, Cursor=0, and clear the edge-detector flops and ring counters.
REQ-030 SHALL let reset mid-RUN or mid-PROG override all other inputs in that cycle.

Configuration
REQ-031 SHALL, when CRONO_AUTORELOAD_EN is defined, latch each channel's programmed value on PROG exit.
REQ-032 SHALL, when CRONO_AUTORELOAD_EN is defined, reload the latched value on expiry and keep the channel in RUN with Ring pulsed high for RING_TICKS ticks; a start/stop edge SHALL stop it.
REQ-033 SHALL, when CRONO_AUTORELOAD_EN is undefined, stop at zero per REQ-025 and REQ-026, with no reload storage synthesised.

Structure
REQ-034 SHALL place the channel-state enum, the cursor-field enum and the BCD limits (59, 23) in shared package crono_pkg.
REQ-035 SHALL implement one per-channel sub-module crono_channel (state, BCD counter, ring counter), generated N_CH times; the top SHALL hold the edge detection, cursor FSM and output mux.

Verification
REQ-036 SHALL verify: ch0 at 00:00:58, arriba x2 -> 00:00:00 (wrap, minutes unchanged).
REQ-037 SHALL verify: cursor 1, izquierda x3 -> Cursor=3; abajo from 00 -> hours 23.
REQ-038 SHALL verify: ch0 at 00:01:00, start, 1 tick -> 00:00:59; at 60 ticks -> Ring[0]=1 and CronoActivo[0]=0; RING_TICKS ticks later -> Ring[0]=0.
REQ-039 SHALL verify: ch0 RUN and ch1 PROG at the same time -> ch0 keeps decrementing while ch1 edits.
REQ-040 SHALL verify: tick and start/stop edge in the same cycle -> channel stops at its pre-tick value.
REQ-041 SHALL verify: Reset mid-RUN at 01:23:45 -> next cycle 00:00:00, all outputs zero; with CRONO_AUTORELOAD_EN at 00:00:03 -> reload to 00:00:03 after 3 ticks, still RUN.
